// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : player_pkg
//  Description : Shared types, geometry defaults and the box scoring helper
//                for the player stack manager.
//  Revision    : 1.0 - initial release
// ============================================================================
package player_pkg;

    // Stack manager control states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UNLOAD = 1'b1
    } state_t;

    // Default box geometry in pixels
    localparam int c_BASE_HEIGHT = 30;
    localparam int c_BOX_HEIGHT  = 30;
    localparam int c_MAX_BOXES   = 4;

    // A banked box is worth 2^type points
    function automatic logic [31:0] box_points(input logic [7:0] box_type);
        return 32'd1 << box_type;
    endfunction

endpackage : player_pkg
`default_nettype wire

// File: rtl/box_lifo.sv
`default_nettype none
// ============================================================================
//  Module      : box_lifo
//  Description : Typed LIFO of caught boxes. Pushes into a full stack and
//                pops from an empty one are rejected in the same cycle.
//                Pop wins if both are requested together.
//  Revision    : 1.0 - initial release
// ============================================================================
module box_lifo
    import player_pkg::*;
#(
    parameter int MAX_BOXES = c_MAX_BOXES,
    parameter int TYPE_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [TYPE_W-1:0] i_din,
    output logic [3:0]        o_count,
    output logic [TYPE_W-1:0] o_top,
    output logic              o_full
);

    localparam logic [3:0] c_MAX = 4'(MAX_BOXES);

    logic [3:0]        r_count;
    logic [TYPE_W-1:0] r_mem [MAX_BOXES];
    logic              w_do_pop;
    logic              w_do_push;
    logic [TYPE_W-1:0] w_top;

    assign w_do_pop  = i_pop && (r_count != 4'd0);
    assign w_do_push = i_push && !i_pop && (r_count != c_MAX);

    // Stack depth tracks accepted pushes and pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (w_do_pop) begin
            r_count <= r_count - 4'd1;
        end else if (w_do_push) begin
            r_count <= r_count + 4'd1;
        end
    end

    // Accepted push writes the slot just above the current top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_BOXES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            for (int i = 0; i < MAX_BOXES; i++) begin
                if (r_count == 4'(i)) begin
                    r_mem[i] <= i_din;
                end
            end
        end
    end

    // Top-of-stack select; an empty stack reports type 0
    always_comb begin
        w_top = '0;
        for (int i = 0; i < MAX_BOXES; i++) begin
            if (r_count == 4'(i + 1)) begin
                w_top = r_mem[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_top   = w_top;
    assign o_full  = (r_count == c_MAX);

endmodule : box_lifo
`default_nettype wire

// File: rtl/player_stack_manager.sv
`default_nettype none
// ============================================================================
//  Module      : player_stack_manager
//  Description : Tracks the player's stack of caught boxes, derives player
//                height from stack depth and banks boxes one at a time into
//                a saturating score.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_stack_manager
    import player_pkg::*;
#(
    parameter int BASE_HEIGHT  = c_BASE_HEIGHT,
    parameter int BOX_HEIGHT   = c_BOX_HEIGHT,
    parameter int MAX_BOXES    = c_MAX_BOXES,
    parameter int TYPE_W       = 2,
    parameter int UNLOAD_DELAY = 8,
    parameter int SCORE_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               box_caught,
    input  logic [TYPE_W-1:0]  box_type,
    input  logic               box_dropped_in,
    input  logic               hazard_hit,
    output logic [9:0]         current_height,
    output logic [3:0]         box_count,
    output logic [TYPE_W-1:0]  top_type,
    output logic               stack_full,
    output logic               unloading,
    output logic [SCORE_W-1:0] score,
    output logic               deposit_valid,
    output logic [TYPE_W-1:0]  deposit_type,
    output logic               overflow
);

    localparam int                 c_TMR_W     = (UNLOAD_DELAY > 1) ? $clog2(UNLOAD_DELAY) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD  = c_TMR_W'(UNLOAD_DELAY - 1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    state_t               r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_deposit_valid;
    logic [TYPE_W-1:0]    r_deposit_type;
    logic                 r_overflow;
    logic                 r_caught_q;
    logic                 r_dropped_q;
    logic                 r_hazard_q;

    logic                 w_catch_e;
    logic                 w_drop_e;
    logic                 w_hazard_e;
    logic                 w_in_idle;
    logic                 w_start;
    logic [c_TMR_W-1:0]   w_timer_next;
    logic                 w_expire;
    logic                 w_deposit;
    logic                 w_push;
    logic                 w_overflow;
    logic                 w_pop;
    logic [3:0]           w_count;
    logic [TYPE_W-1:0]    w_top;
    logic                 w_full;
    logic [32:0]          w_sum;
    logic [SCORE_W-1:0]   w_score_next;

    // Edges only exist while the game runs, so a freeze also holds events off
    assign w_catch_e  = game_en && box_caught     && !r_caught_q;
    assign w_drop_e   = game_en && box_dropped_in && !r_dropped_q;
    assign w_hazard_e = game_en && hazard_hit     && !r_hazard_q;

    assign w_in_idle  = (r_state == IDLE);

    // Priority in IDLE is hazard > catch > drop; lower edges are dropped
    assign w_start    = w_in_idle && !w_hazard_e && !w_catch_e && w_drop_e && (w_count != 4'd0);
    assign w_push     = w_in_idle && !w_hazard_e && w_catch_e && !w_full;
    assign w_overflow = w_in_idle && !w_hazard_e && w_catch_e && w_full;

    // The pop is decided one cycle ahead so its result appears on the cycle
    // the timer reads zero; with a one-cycle delay the drop itself banks.
    assign w_timer_next = (w_start || (r_timer == '0)) ? c_TMR_LOAD : r_timer - c_TMR_W'(1);
    assign w_expire     = game_en && (w_start || !w_in_idle) && (w_timer_next == '0) && (w_count != 4'd0);
    assign w_deposit    = w_expire && !w_hazard_e;
    assign w_pop        = w_hazard_e || w_deposit;

    // Saturating score add, computed wide so the carry is never lost
    assign w_sum        = 33'(r_score) + {1'b0, box_points(8'(w_top))};
    assign w_score_next = (w_sum > 33'(c_SCORE_MAX)) ? c_SCORE_MAX : w_sum[SCORE_W-1:0];

    box_lifo #(
        .MAX_BOXES (MAX_BOXES),
        .TYPE_W    (TYPE_W)
    ) u_box_lifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (box_type),
        .o_count (w_count),
        .o_top   (w_top),
        .o_full  (w_full)
    );

    // Control FSM, unload timer, score and one-cycle event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_timer         <= '0;
            r_score         <= '0;
            r_deposit_valid <= 1'b0;
            r_deposit_type  <= '0;
            r_overflow      <= 1'b0;
            r_caught_q      <= 1'b0;
            r_dropped_q     <= 1'b0;
            r_hazard_q      <= 1'b0;
        end else begin
            r_deposit_valid <= 1'b0;
            r_overflow      <= 1'b0;
            if (game_en) begin
                r_caught_q  <= box_caught;
                r_dropped_q <= box_dropped_in;
                r_hazard_q  <= hazard_hit;
                r_overflow  <= w_overflow;
                if (w_deposit) begin
                    r_deposit_valid <= 1'b1;
                    r_deposit_type  <= w_top;
                    r_score         <= w_score_next;
                end
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_state <= UNLOAD;
                            r_timer <= w_timer_next;
                        end
                    end
                    UNLOAD: begin
                        r_timer <= w_timer_next;
                        if (w_count == 4'd0) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign current_height = 10'(BASE_HEIGHT) + 10'(w_count) * 10'(BOX_HEIGHT);
    assign box_count      = w_count;
    assign top_type       = w_top;
    assign stack_full     = w_full;
    assign unloading      = (r_state == UNLOAD);
    assign score          = r_score;
    assign deposit_valid  = r_deposit_valid;
    assign deposit_type   = r_deposit_type;
    assign overflow       = r_overflow;

endmodule : player_stack_manager
`default_nettype wire

// File: tb/tb_player_stack_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_stack_manager
//  Description : Scoreboard bench for player_stack_manager with a queue-based
//                reference model, plus a small saturation instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_stack_manager;

    localparam int c_BASE = 30;
    localparam int c_BOXH = 30;
    localparam int c_MAXB = 4;
    localparam int c_TW   = 2;
    localparam int c_DLY  = 8;
    localparam int c_SW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance at default parameters
    logic              game_en, box_caught, box_dropped_in, hazard_hit;
    logic [c_TW-1:0]   box_type;
    logic [9:0]        current_height;
    logic [3:0]        box_count;
    logic [c_TW-1:0]   top_type;
    logic              stack_full, unloading, deposit_valid, overflow;
    logic [c_SW-1:0]   score;
    logic [c_TW-1:0]   deposit_type;

    player_stack_manager dut (
        .clk(clk), .rst(rst), .game_en(game_en), .box_caught(box_caught),
        .box_type(box_type), .box_dropped_in(box_dropped_in), .hazard_hit(hazard_hit),
        .current_height(current_height), .box_count(box_count), .top_type(top_type),
        .stack_full(stack_full), .unloading(unloading), .score(score),
        .deposit_valid(deposit_valid), .deposit_type(deposit_type), .overflow(overflow)
    );

    // Small-score instance for saturation
    logic              s_game_en, s_box_caught, s_box_dropped_in, s_hazard_hit;
    logic [1:0]        s_box_type;
    logic [9:0]        s_current_height;
    logic [3:0]        s_box_count;
    logic [1:0]        s_top_type;
    logic              s_stack_full, s_unloading, s_deposit_valid, s_overflow;
    logic [3:0]        s_score;
    logic [1:0]        s_deposit_type;

    player_stack_manager #(.MAX_BOXES(5), .SCORE_W(4)) dut_s (
        .clk(clk), .rst(rst), .game_en(s_game_en), .box_caught(s_box_caught),
        .box_type(s_box_type), .box_dropped_in(s_box_dropped_in), .hazard_hit(s_hazard_hit),
        .current_height(s_current_height), .box_count(s_box_count), .top_type(s_top_type),
        .stack_full(s_stack_full), .unloading(s_unloading), .score(s_score),
        .deposit_valid(s_deposit_valid), .deposit_type(s_deposit_type), .overflow(s_overflow)
    );

    typedef struct {
        int height; int count; int top; int full; int unl;
        int score;  int dv;    int dt;  int ov;
    } snap_t;

    snap_t exp_q[$];
    int    dep_type_q[$];
    int    dep_score_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: stack as a queue, phase counted in enabled cycles
    int    m_stk[$];
    bit    m_unl;
    int    m_ph;
    int    m_score;
    bit    m_pc, m_pd, m_phz;
    snap_t m_snap;
    snap_t mon_snap;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_unl = 1'b0; m_ph = 0; m_score = 0;
        m_pc = 1'b0; m_pd = 1'b0; m_phz = 1'b0;
    endtask

    task automatic model_bank();
        int tp;
        tp = m_stk.pop_back();
        m_score = m_score + (1 << tp);
        if (m_score > (1 << c_SW) - 1) m_score = (1 << c_SW) - 1;
        m_snap.dv = 1;
        m_snap.dt = tp;
        dep_type_q.push_back(tp);
        dep_score_q.push_back(m_score);
    endtask

    task automatic model_step(input bit en, input bit c, input int t, input bit d, input bit h);
        bit ce, de, he;
        m_snap.dv = 0; m_snap.dt = 0; m_snap.ov = 0;
        if (en) begin
            ce = c && !m_pc; de = d && !m_pd; he = h && !m_phz;
            m_pc = c; m_pd = d; m_phz = h;
            if (!m_unl) begin
                if (he) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                end else if (ce) begin
                    if (m_stk.size() == c_MAXB) m_snap.ov = 1;
                    else m_stk.push_back(t);
                end else if (de && m_stk.size() > 0) begin
                    m_unl = 1'b1;
                    m_ph  = 0;
                    if (c_DLY == 1) model_bank();
                end
            end else if (m_stk.size() == 0) begin
                m_unl = 1'b0;
            end else begin
                m_ph++;
                if (he) void'(m_stk.pop_back());
                else if ((m_ph % c_DLY) == c_DLY - 1) model_bank();
            end
        end
        m_snap.count  = m_stk.size();
        m_snap.height = c_BASE + m_stk.size() * c_BOXH;
        m_snap.top    = (m_stk.size() > 0) ? m_stk[$] : 0;
        m_snap.full   = (m_stk.size() == c_MAXB) ? 1 : 0;
        m_snap.unl    = m_unl ? 1 : 0;
        m_snap.score  = m_score;
    endtask

    // One clock of stimulus; expectation is queued at the edge it applies to
    task automatic step(input bit en, input bit c, input int t, input bit d, input bit h);
        int tt;
        tt = t % (1 << c_TW);
        game_en = en; box_caught = c; box_type = c_TW'(tt);
        box_dropped_in = d; hazard_hit = h;
        model_step(en, c, tt, d, h);
        @(posedge clk);
        exp_q.push_back(m_snap);
        #1;
    endtask

    task automatic catch_box(input int t);
        step(1'b1, 1'b1, t, 1'b0, 1'b0);
        step(1'b1, 1'b0, t, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each cycle's outputs, and each deposit against its queue
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_snap = exp_q.pop_front();
                chk("height",    current_height, mon_snap.height);
                chk("count",     box_count,      mon_snap.count);
                chk("top_type",  top_type,       mon_snap.top);
                chk("full",      stack_full,     mon_snap.full);
                chk("unloading", unloading,      mon_snap.unl);
                chk("score",     score,          mon_snap.score);
                chk("dep_valid", deposit_valid,  mon_snap.dv);
                chk("overflow",  overflow,       mon_snap.ov);
            end
            if (deposit_valid === 1'b1) begin
                if (dep_type_q.size() == 0) begin
                    chk("dep_unexpected", deposit_valid, 0);
                end else begin
                    chk("dep_type",  deposit_type, dep_type_q.pop_front());
                    chk("dep_score", score,        dep_score_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_dep;
        int s_exp;
        rst = 1'b0;
        game_en = 1'b0; box_caught = 1'b0; box_type = '0; box_dropped_in = 1'b0; hazard_hit = 1'b0;
        s_game_en = 1'b0; s_box_caught = 1'b0; s_box_type = '0; s_box_dropped_in = 1'b0; s_hazard_hit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_height",   current_height, 30);
        chk("rst_count",    box_count,      0);
        chk("rst_score",    score,          0);
        chk("rst_dep",      deposit_valid,  0);
        chk("rst_overflow", overflow,       0);
        chk("rst_unload",   unloading,      0);
        chk("rst_top",      top_type,       0);
        rst = 1'b1;

        // Catch up to overflow
        catch_box(1); catch_box(2); catch_box(3); catch_box(0); catch_box(2);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        end

        // Banking two boxes
        catch_box(1); catch_box(3);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(20);

        // Hazard coinciding with the first timer expiry
        catch_box(2); catch_box(2); catch_box(2);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(6);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        idle(25);

        // Simultaneous catch and hazard in IDLE
        catch_box(1);
        step(1'b1, 1'b1, 3, 1'b0, 1'b1);
        idle(2);

        // Freeze in the middle of an unload
        catch_box(1); catch_box(2);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 8) != 0, ($urandom % 4) == 0, int'($urandom % 4),
                 ($urandom % 10) == 0, ($urandom % 14) == 0);
        end
        idle(50);
        @(negedge clk); #1;
        chk("dep_queue_drained", dep_type_q.size(), 0);

        // Asynchronous reset in the middle of an unload
        catch_box(1); catch_box(2);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(3);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_count",  box_count,      0);
        chk("arst_height", current_height, 30);
        chk("arst_unload", unloading,      0);
        chk("arst_score",  score,          0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle(3);

        // Saturation: five type-2 boxes into a 4-bit score
        s_game_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_box_caught = 1'b1; s_box_type = 2'd2;
            @(posedge clk); #1;
            s_box_caught = 1'b0;
            @(posedge clk); #1;
        end
        chk("sat_full", s_stack_full, 1);
        s_box_dropped_in = 1'b1;
        @(posedge clk); #1;
        s_box_dropped_in = 1'b0;
        n_dep = 0;
        s_exp = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_deposit_valid === 1'b1) begin
                n_dep++;
                s_exp = (s_exp + 4 > 15) ? 15 : s_exp + 4;
                chk("sat_step", s_score, s_exp);
            end
        end
        chk("sat_deposits", n_dep,       5);
        chk("sat_score",    s_score,     15);
        chk("sat_count",    s_box_count, 0);
        chk("sat_unload",   s_unloading, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_player_stack_manager
`default_nettype wire

// File: doc/player_stack_manager.md
# player_stack_manager

Parametrised successor to the player height tracker. Holds a typed LIFO stack of caught boxes, derives player height from stack depth, and scores boxes when the player banks them. Unloading is sequenced, one box per `UNLOAD_DELAY` cycles, instead of instantaneous. Sits between the collision/catch logic and the score/display path.

## Interface
- `BASE_HEIGHT`, default 30: height in pixels with an empty stack.
- `BOX_HEIGHT`, default 30: height added per stacked box.
- `MAX_BOXES`, default 4: stack capacity, range 1..15. `BASE_HEIGHT + MAX_BOXES*BOX_HEIGHT` must be ≤ 1023.
- `TYPE_W`, default 2: box type width.
- `UNLOAD_DELAY`, default 8: cycles per banked box, ≥ 1.
- `SCORE_W`, default 16: score width.

Ports (reset is asynchronous, active-low):
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous active-low reset.
- `game_en`, in, 1: when low, all state is frozen, including edge-detect registers and the unload timer.
- `box_caught`, in, 1: level; a rising edge means a box was caught.
- `box_type`, in, TYPE_W: type of the caught box, sampled on the catch edge.
- `box_dropped_in`, in, 1: level; a rising edge starts banking.
- `hazard_hit`, in, 1: level; a rising edge loses the top box.
- `current_height`, out, 10: equals `BASE_HEIGHT + box_count*BOX_HEIGHT`. Reset value is `BASE_HEIGHT`.
- `box_count`, out, 4: current stack depth. Reset value 0.
- `top_type`, out, TYPE_W: type of the top box; 0 when the stack is empty. Reset value 0.
- `stack_full`, out, 1: asserted when `box_count == MAX_BOXES`. Reset value 0.
- `unloading`, out, 1: high while in UNLOAD. Reset value 0.
- `score`, out, SCORE_W: accumulated, saturating. Reset value 0.
- `deposit_valid`, out, 1: one-cycle pulse per banked box. Reset value 0.
- `deposit_type`, out, TYPE_W: type of the banked box; valid with `deposit_valid`. Reset value 0.
- `overflow`, out, 1: one-cycle pulse when a catch arrives while the stack is full. Reset value 0.

## Operation
- **Edge detection.** Each of the three level inputs has a registered copy. An edge is `in && !in_q`. The `_q` registers update only when `game_en` is high.
- **FSM states.**
  - IDLE:
    - Per-cycle priority is hazard > catch > drop. Lower-priority edges arriving in the same cycle are discarded.
    - Hazard: pop the top box with no score. It is a no-op if the stack is empty.
    - Catch: push `box_type` if not full. If full, ignore the catch and pulse `overflow`.
    - Drop edge with `box_count > 0`: go to UNLOAD and load the timer with `UNLOAD_DELAY-1`. With `box_count == 0`, stay in IDLE.
  - UNLOAD:
    - Catch edges are discarded, with no overflow pulse.
    - A hazard edge pops the top box with no score. The timer keeps running.
    - When the timer reaches 0: pop, add points to `score`, and pulse `deposit_valid` with `deposit_type` = the popped type. Then reload the timer.
    - Return to IDLE in the cycle the pop (deposit or hazard) leaves the stack empty.
    - Hazard and timer expiry in the same cycle: the hazard pop takes priority and no deposit occurs that cycle. The timer still reloads.
- **Points.** Points = `1 << box_type`, zero-extended to SCORE_W. The add saturates at all-ones.
- **Height arithmetic.** 10-bit unsigned arithmetic; no wrap, by the parameter constraint.
- **Reset.** Reset in any state returns to IDLE, empties the stack, and clears score and pulses immediately.

## Timing
- A catch edge in cycle T updates `box_count`, `current_height`, `top_type` and `stack_full` at T+1. The same applies to hazard pops.
- A drop edge in cycle T puts `unloading` high at T+1.
- The first `deposit_valid` is at T+`UNLOAD_DELAY`. Subsequent deposits are spaced every `UNLOAD_DELAY` cycles.
- `score`, `box_count` and `current_height` update in the same cycle that `deposit_valid` is high.
- `unloading` falls in the cycle after the last pop.
- All outputs are registered; there are no combinational input-to-output paths.
- With `game_en` low for N cycles, every timing above stretches by N.

## Structure
- **Package `player_pkg`** holds:
  - the state enum (IDLE, UNLOAD),
  - the `box_points` function,
  - the default localparams for box geometry.
- **Sub-module `box_lifo`** holds:
  - `MAX_BOXES × TYPE_W` storage with a push/pop interface, including same-cycle rejection when full or empty,
  - the `count`, `top` and `full` outputs.
- **Top level** holds the edge detectors, FSM, timer, score and height registers.

## Test plan
- **Reset values.** Reset, then release → `current_height`=30, `box_count`=0, `score`=0 and all pulses 0.
- **Catch to overflow.** Catch types 1,2,3,0,2 with defaults → height rises 60, 90, 120, 150. The 5th catch gives `overflow`=1 for one cycle, height stays 150, and `top_type`=0.
- **Banking.** Stack 1,3, then drop edge at T → `deposit_valid` at T+8 with type 3, score 8. Then T+16 with type 1, score 10. `unloading` low at T+17 and height 30.
- **Hazard during UNLOAD.** Stack 2,2,2, drop, then a hazard edge in the same cycle the timer expires → one box lost, no deposit that cycle. Remaining two deposits give a final score of 8.
- **Simultaneous edges and freeze.** Catch and hazard edges in the same IDLE cycle with 1 box → count 0 and no push. Holding `game_en` low mid-UNLOAD delays `deposit_valid` by exactly the stall length.
- **Score saturation.** `SCORE_W`=4, bank five type-2 boxes (`MAX_BOXES`=5) → score saturates at 15 and does not wrap.
